// File: rtl/vend_controller.sv
// Multi-item vending controller: coin credit, per-item pricing, greedy change dispense.
// Optional AUTO_CHANGE_EN: leftover credit after a successful vend is returned automatically.
module vend_controller #(
    parameter int NUM_ITEMS = 4,
    parameter int SEL_W = 2,
    parameter int CREDIT_W = 16,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TABLE = {16'd50, 16'd125, 16'd75, 16'd100},
    parameter int NICKEL_VAL = 5,
    parameter int DIME_VAL = 10,
    parameter int QUARTER_VAL = 25,
    parameter int CREDIT_MAX = 995
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_nickel,
    input  logic                coin_dime,
    input  logic                coin_quarter,
    input  logic                buy,
    input  logic [SEL_W-1:0]    item_sel,
    input  logic                coin_return,
    input  logic                hopper_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [SEL_W-1:0]    vend_item,
    output logic                insufficient,
    output logic                coin_reject,
    output logic                disp_nickel,
    output logic                disp_dime,
    output logic                disp_quarter,
    output logic                busy
);
    localparam logic [CREDIT_W-1:0] NICKEL  = CREDIT_W'(NICKEL_VAL);
    localparam logic [CREDIT_W-1:0] DIME    = CREDIT_W'(DIME_VAL);
    localparam logic [CREDIT_W-1:0] QUARTER = CREDIT_W'(QUARTER_VAL);
    localparam logic [CREDIT_W:0]   CMAX    = (CREDIT_W+1)'(CREDIT_MAX);

    typedef enum logic {IDLE, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]    vend_item_q, vend_item_d;
    logic                insufficient_q, insufficient_d;
    logic                coin_reject_q, coin_reject_d;

    logic [CREDIT_W-1:0] coin_sum, price, credit_after, coin_val;
    logic                any_coin, coin_fits, sel_ok, buy_ok, buy_fail, go_change;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            insufficient_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            insufficient_q <= insufficient_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_valid_d   = 1'b0;
        vend_item_d    = vend_item_q;
        insufficient_d = insufficient_q;
        coin_reject_d  = 1'b0;
        disp_nickel    = 1'b0;
        disp_dime      = 1'b0;
        disp_quarter   = 1'b0;
        coin_val       = '0;
        price          = '0;
        go_change      = 1'b0;

        any_coin = coin_nickel | coin_dime | coin_quarter;
        coin_sum = (coin_nickel ? NICKEL : '0) + (coin_dime ? DIME : '0)
                 + (coin_quarter ? QUARTER : '0);
        // Acceptance is judged on pre-cycle credit with one spare bit so it cannot wrap.
        coin_fits = ({1'b0, credit_q} + {1'b0, coin_sum}) <= CMAX;

        sel_ok = 32'(item_sel) < NUM_ITEMS;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (32'(item_sel) == i) price = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
        end
        buy_ok   = buy && sel_ok && (credit_q >= price);
        buy_fail = buy && sel_ok && (credit_q < price);
        credit_after = credit_q - (buy_ok ? price : '0) + (coin_fits ? coin_sum : '0);

        case (state_q)
            IDLE: begin
                credit_d      = credit_after;
                coin_reject_d = any_coin && !coin_fits;
                if (any_coin && coin_fits) insufficient_d = 1'b0;
                if (buy_ok) begin
                    vend_valid_d   = 1'b1;
                    vend_item_d    = item_sel;
                    insufficient_d = 1'b0;
                end
                if (buy_fail) insufficient_d = 1'b1;
`ifdef AUTO_CHANGE_EN
                go_change = coin_return || buy_ok;
`else
                go_change = coin_return;
`endif
                if (go_change && credit_after >= NICKEL) begin
                    state_d        = CHANGE;
                    insufficient_d = 1'b0;
                end
            end
            CHANGE: begin
                coin_reject_d = any_coin;
                // Greedy pick is a pure function of held credit, so it stays put while the hopper stalls.
                if (credit_q >= QUARTER) begin
                    disp_quarter = 1'b1;
                    coin_val     = QUARTER;
                end else if (credit_q >= DIME) begin
                    disp_dime = 1'b1;
                    coin_val  = DIME;
                end else if (credit_q >= NICKEL) begin
                    disp_nickel = 1'b1;
                    coin_val    = NICKEL;
                end else begin
                    state_d = IDLE;
                end
                if (hopper_ready && coin_val != '0) begin
                    credit_d = credit_q - coin_val;
                    if (credit_d < NICKEL) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign credit       = credit_q;
    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign insufficient = insufficient_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = (state_q == CHANGE);
endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Parametrised multi-item vending controller and the successor to the single-price credit/buy logic.
- Accumulates credit from debounced coin pulses.
- Sells one of NUM_ITEMS items at per-item prices.
- Flags insufficient funds.
- Returns change through a greedy coin-dispense state machine with a hopper ready handshake.
- Sits between the input debouncers and the display/hopper drivers; credit output feeds the 7-segment display path.

Parameters:
NUM_ITEMS, 4, number of selectable items (>=1)
SEL_W, 2, width of item_sel; must satisfy 2**SEL_W >= NUM_ITEMS
CREDIT_W, 16, width of credit register and prices
PRICE_TABLE, {16'd50,16'd125,16'd75,16'd100}, packed NUM_ITEMS*CREDIT_W prices; item i at bits [i*CREDIT_W +: CREDIT_W]
NICKEL_VAL, 5, value of nickel
DIME_VAL, 10, value of dime
QUARTER_VAL, 25, value of quarter
CREDIT_MAX, 995, maximum credit held; must fit in CREDIT_W

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
coin_nickel  in  1  single-cycle pulse, nickel inserted
coin_dime  in  1  single-cycle pulse, dime inserted
coin_quarter  in  1  single-cycle pulse, quarter inserted
buy  in  1  single-cycle pulse, purchase request
item_sel  in  SEL_W  item index, sampled with buy
coin_return  in  1  single-cycle pulse, request return of all credit
hopper_ready  in  1  hopper accepts one coin this cycle
credit  out  CREDIT_W  current credit (registered)
vend_valid  out  1  one-cycle pulse, item dispensed
vend_item  out  SEL_W  index of vended item, valid with vend_valid
insufficient  out  1  level, last buy failed for lack of funds
coin_reject  out  1  one-cycle pulse, inserted coin(s) refused
disp_nickel  out  1  request hopper eject nickel
disp_dime  out  1  request hopper eject dime
disp_quarter  out  1  request hopper eject quarter
busy  out  1  high while in CHANGE state

Behaviour:
- Reset (synchronous): all outputs 0, credit=0, state=IDLE. Reset mid-CHANGE aborts dispensing immediately; the undispensed credit is lost.
- States: IDLE and CHANGE.
- IDLE, per cycle, with all decisions on pre-cycle credit C:
  - Coins:
    - coin_sum = sum of the values of the asserted coin pulses; simultaneous coins are summed.
    - Accepted if C + coin_sum <= CREDIT_MAX; otherwise all coins that cycle are rejected and coin_reject pulses for one cycle.
  - Buy:
    - Valid only if item_sel < NUM_ITEMS; an invalid select is ignored with no output change.
    - If C >= price: credit deducted, vend_valid=1 and vend_item=item_sel registered (1-cycle latency), insufficient cleared.
    - Else: insufficient set; credit unchanged.
  - Next credit = C - (price if vend) + (coin_sum if accepted).
  - Coin acceptance is evaluated with pre-buy C, and coins are never used to fund the same-cycle buy.
  - Any accepted coin clears insufficient, unless the same-cycle buy fails (set wins).
  - coin_return with credit >= NICKEL_VAL: go to CHANGE next cycle. Same-cycle coins and buy are processed first; coin_return has lowest priority.
  - coin_return with credit < NICKEL_VAL: ignored.
- CHANGE:
  - busy=1.
  - Exactly one disp_* is high, chosen greedily: quarter if credit >= QUARTER_VAL, else dime if credit >= DIME_VAL, else nickel.
  - Transfer happens in a cycle where disp_x & hopper_ready. In that cycle credit is reduced by the coin value; the next selection is made from the new credit.
  - disp_* is held stable while hopper_ready is low.
  - When credit < NICKEL_VAL: all disp_*=0, return to IDLE. Any residue below NICKEL_VAL remains as credit.
  - Coins inserted during CHANGE are rejected (coin_reject pulse). buy and coin_return are ignored.
  - insufficient is cleared on entry.
- vend_valid and coin_reject are never held longer than one cycle.
- All arithmetic is unsigned CREDIT_W-bit. Underflow cannot occur by construction.

Optional Feature:
AUTO_CHANGE_EN:
- Defined: a successful vend with remaining credit >= NICKEL_VAL enters CHANGE on the cycle after vend_valid. Coins accepted in the vend cycle are included in the returned change.
- Undefined: remaining credit persists after a vend; change is returned only via coin_return.

Test Plan:
- Reset, then 4 quarters, then buy item_sel=0 (price 100) -> vend_valid pulse with vend_item=0, credit 100->0, insufficient=0.
- Credit 30, buy item_sel=2 (price 125) -> insufficient=1, credit stays 30; then a dime -> credit 40, insufficient=0.
- Credit 990, coin_quarter -> coin_reject pulse, credit stays 990; a nickel in the same cycle as a dime at credit 980 -> credit 995.
- Credit 40, coin_return, hopper_ready toggling 1,0,1,1 -> disp_quarter handshake (credit 15), disp_dime held while ready=0 then accepted (credit 5), disp_nickel (credit 0), busy drops, IDLE.
- Credit 65 in CHANGE after one quarter dispensed, reset asserted -> next cycle credit=0, busy=0, all disp_*=0.
- AUTO_CHANGE_EN defined: credit 110, buy item 0 -> vend_valid, then busy=1 and one dime dispensed, credit 0. Undefined: credit stays 10.
